axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 The block SHALL have the parameter ADDR_WIDTH, default 32, giving the AXI and command address width.
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 32, giving the data width; only 32 is supported, and WSTRB width is DATA_WIDTH/8.
REQ-003 The block SHALL have the port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have the port ARESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have the port CMD_VALID, input, 1 bit: command request.
REQ-006 The block SHALL have the port CMD_READY, output, 1 bit: command accepted.
REQ-007 The block SHALL have the port CMD_WRITE, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have the port CMD_ADDR, input, ADDR_WIDTH bits: byte address.
REQ-009 The block SHALL have the ports CMD_WDATA (input, DATA_WIDTH bits) and CMD_WSTRB (input, 4 bits): write payload.
REQ-010 The block SHALL have the ports RSP_VALID (output, 1 bit) and RSP_READY (input, 1 bit): response handshake.
REQ-011 The block SHALL have the port RSP_WRITE, output, 1 bit: the response belongs to a write.
REQ-012 The block SHALL have the ports RSP_RDATA (output, DATA_WIDTH bits) and RSP_RESP (output, 2 bits): read data and BRESP/RRESP.
REQ-013 The block SHALL have the AXI4-Lite master write ports:
- M_AXIL_AWADDR, M_AXIL_AWVALID, M_AXIL_AWREADY
- M_AXIL_WDATA, M_AXIL_WSTRB, M_AXIL_WVALID, M_AXIL_WREADY
- M_AXIL_BRESP, M_AXIL_BVALID, M_AXIL_BREADY
REQ-014 The block SHALL have the AXI4-Lite master read ports:
- M_AXIL_ARADDR, M_AXIL_ARVALID, M_AXIL_ARREADY
- M_AXIL_RDATA, M_AXIL_RRESP, M_AXIL_RVALID, M_AXIL_RREADY
REQ-015 The block SHALL have the ports WR_COUNT and RD_COUNT, outputs, 16 bits each: completed-transaction counters.
REQ-016 The block SHALL have the port BUSY, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM states SHALL be IDLE, WR_AW_W, WR_B, RD_AR, RD_R and RSP.
REQ-018 CMD_READY SHALL be high only in IDLE; a command is accepted on CMD_VALID&CMD_READY, with address, data, strobe and direction registered.
REQ-019 After a write is accepted, the FSM SHALL move IDLE->WR_AW_W, with AWVALID and WVALID both asserting on the next cycle.
REQ-020 AW and W SHALL complete independently: each VALID drops the cycle after its own handshake, and the other VALID stays high until its handshake.
REQ-021 When both AW and W are done (including the same cycle), the FSM SHALL move WR_AW_W->WR_B.
REQ-022 In WR_B, BREADY SHALL be high; on BVALID&BREADY, BRESP is captured and the FSM moves WR_B->RSP.
REQ-023 After a read is accepted, the FSM SHALL move IDLE->RD_AR, with ARVALID high until ARREADY, then move to RD_R.
REQ-024 In RD_R, RREADY SHALL be high; on RVALID&RREADY, RDATA and RRESP are captured and the FSM moves to RSP.
REQ-025 In RSP, RSP_VALID SHALL be high with stable RSP_* outputs; on RSP_READY the FSM moves RSP->IDLE, and a new command can be accepted in the following cycle.
REQ-026 The block SHALL have at most one outstanding transaction; CMD_VALID outside IDLE is ignored.
REQ-027 AW/W/AR address and data SHALL be held stable while the corresponding VALID is high, and no VALID depends combinationally on any READY.
REQ-028 BREADY and RREADY SHALL be low outside WR_B and RD_R respectively.
REQ-029 For a write, RSP_RDATA SHALL be 0 and RSP_WRITE=1.
REQ-030 WR_COUNT/RD_COUNT SHALL increment on the B/R handshake regardless of response code, wrapping 0xFFFF->0x0000.
REQ-031 Latency: with zero-wait slaves, command accept at cycle N gives RSP_VALID at N+3, through one cycle each in WR_AW_W/RD_AR and WR_B/RD_R.
REQ-032 SLVERR/DECERR SHALL be passed through unmodified on RSP_RESP.

Reset
REQ-033 While ARESET is high, the block SHALL go to IDLE immediately, without waiting for a clock edge.
REQ-034 While ARESET is high, all VALID/READY outputs SHALL be 0, except CMD_READY, which is 0 during reset.
REQ-035 While ARESET is high, all address, data and RSP_* outputs, WR_COUNT, RD_COUNT and BUSY SHALL be 0.
REQ-036 After ARESET deasserts, CMD_READY SHALL assert on the first clock edge after release.
REQ-037 Reset mid-transaction SHALL abandon the transaction with no response and no counter increment.

Verification
REQ-038 Write 0x00000040 data 0x0100ABCD, strb 0xF, zero-wait slave, BRESP=00 -> AWADDR=0x40 and WDATA=0x0100ABCD seen; RSP_VALID at accept+3; RSP_WRITE=1, RSP_RESP=00; WR_COUNT=1.
REQ-039 Read 0x00000040 with slave RDATA=0x0100ABCD, RVALID delayed 5 cycles -> RREADY held high for 5 cycles; RSP_RDATA=0x0100ABCD; RD_COUNT=1.
REQ-040 WREADY 3 cycles after AWREADY -> AWVALID drops after its handshake while WVALID stays high; exactly one AW and one W handshake occur.
REQ-041 RSP_READY held low for 4 cycles -> RSP_VALID and RSP_RDATA stay stable; CMD_VALID during that time is not accepted.
REQ-042 Slave returns RRESP=10 -> RSP_RESP=10 and RD_COUNT increments.
REQ-043 ARESET pulsed while in WR_B -> all outputs are 0 asynchronously; after release the next write completes normally and WR_COUNT=1.

Source files
------------

// File: rtl/axi_lite_master_if.sv
// Command/response handshake and AXI4-Lite master bus bundle for axi_lite_master.
// The master modport is the DUT view; the slave modport is the environment view.
interface axi_lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WRITE;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [DATA_WIDTH-1:0] CMD_WDATA;
  logic [STRB_WIDTH-1:0] CMD_WSTRB;

  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic                  RSP_WRITE;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic [1:0]            RSP_RESP;

  logic [ADDR_WIDTH-1:0] M_AXIL_AWADDR;
  logic                  M_AXIL_AWVALID;
  logic                  M_AXIL_AWREADY;
  logic [DATA_WIDTH-1:0] M_AXIL_WDATA;
  logic [STRB_WIDTH-1:0] M_AXIL_WSTRB;
  logic                  M_AXIL_WVALID;
  logic                  M_AXIL_WREADY;
  logic [1:0]            M_AXIL_BRESP;
  logic                  M_AXIL_BVALID;
  logic                  M_AXIL_BREADY;

  logic [ADDR_WIDTH-1:0] M_AXIL_ARADDR;
  logic                  M_AXIL_ARVALID;
  logic                  M_AXIL_ARREADY;
  logic [DATA_WIDTH-1:0] M_AXIL_RDATA;
  logic [1:0]            M_AXIL_RRESP;
  logic                  M_AXIL_RVALID;
  logic                  M_AXIL_RREADY;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB,
    output CMD_READY,
    output RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP,
    input  RSP_READY,
    output M_AXIL_AWADDR, M_AXIL_AWVALID,
    input  M_AXIL_AWREADY,
    output M_AXIL_WDATA, M_AXIL_WSTRB, M_AXIL_WVALID,
    input  M_AXIL_WREADY,
    input  M_AXIL_BRESP, M_AXIL_BVALID,
    output M_AXIL_BREADY,
    output M_AXIL_ARADDR, M_AXIL_ARVALID,
    input  M_AXIL_ARREADY,
    input  M_AXIL_RDATA, M_AXIL_RRESP, M_AXIL_RVALID,
    output M_AXIL_RREADY
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB,
    input  CMD_READY,
    input  RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP,
    output RSP_READY,
    input  M_AXIL_AWADDR, M_AXIL_AWVALID,
    output M_AXIL_AWREADY,
    input  M_AXIL_WDATA, M_AXIL_WSTRB, M_AXIL_WVALID,
    output M_AXIL_WREADY,
    output M_AXIL_BRESP, M_AXIL_BVALID,
    input  M_AXIL_BREADY,
    input  M_AXIL_ARADDR, M_AXIL_ARVALID,
    output M_AXIL_ARREADY,
    output M_AXIL_RDATA, M_AXIL_RRESP, M_AXIL_RVALID,
    input  M_AXIL_RREADY
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI write or read
// and returns the response on a valid/ready channel, counting completed transfers.
module axi_lite_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi_lite_master_if.master bus,
  output logic [15:0]       WR_COUNT,
  output logic [15:0]       RD_COUNT,
  output logic              BUSY
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_cmd_ready;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;
  logic [CNT_WIDTH-1:0]  r_wr_count;
  logic [CNT_WIDTH-1:0]  r_rd_count;

  logic w_awvalid;
  logic w_wvalid;
  logic w_bready;
  logic w_arvalid;
  logic w_rready;
  logic w_rsp_valid;
  logic w_busy;

  logic w_cmd_acc;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_rsp_hs;

  assign w_cmd_acc = bus.CMD_VALID & r_cmd_ready;
  assign w_aw_hs   = w_awvalid & bus.M_AXIL_AWREADY;
  assign w_w_hs    = w_wvalid & bus.M_AXIL_WREADY;
  assign w_b_hs    = w_bready & bus.M_AXIL_BVALID;
  assign w_ar_hs   = w_arvalid & bus.M_AXIL_ARREADY;
  assign w_r_hs    = w_rready & bus.M_AXIL_RVALID;
  assign w_rsp_hs  = w_rsp_valid & bus.RSP_READY;

  // State register; reset forces IDLE without a clock edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_cmd_acc) w_next_state = bus.CMD_WRITE ? WR_AW_W : RD_AR;
      WR_AW_W: if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_next_state = WR_B;
      WR_B:    if (w_b_hs) w_next_state = RSP;
      RD_AR:   if (w_ar_hs) w_next_state = RD_R;
      RD_R:    if (w_r_hs) w_next_state = RSP;
      RSP:     if (w_rsp_hs) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs decode from registered state only, never from a READY.
  always_comb begin
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE:    w_busy = 1'b0;
      WR_AW_W: begin
        w_awvalid = ~r_aw_done;
        w_wvalid  = ~r_w_done;
      end
      WR_B:    w_bready    = 1'b1;
      RD_AR:   w_arvalid   = 1'b1;
      RD_R:    w_rready    = 1'b1;
      RSP:     w_rsp_valid = 1'b1;
      default: w_busy      = 1'b1;
    endcase
  end

  // Command capture, per-channel completion flags, response capture and counters.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_cmd_ready <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rdata     <= '0;
      r_resp      <= '0;
      r_wr_count  <= '0;
      r_rd_count  <= '0;
    end else begin
      r_cmd_ready <= (w_next_state == IDLE);
      case (r_state)
        IDLE: begin
          if (w_cmd_acc) begin
            r_write   <= bus.CMD_WRITE;
            r_addr    <= bus.CMD_ADDR;
            r_wdata   <= bus.CMD_WDATA;
            r_wstrb   <= bus.CMD_WSTRB;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        WR_AW_W: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        WR_B: begin
          if (w_b_hs) begin
            r_resp     <= bus.M_AXIL_BRESP;
            r_rdata    <= '0;
            r_wr_count <= r_wr_count + CNT_WIDTH'(1);
          end
        end
        RD_R: begin
          if (w_r_hs) begin
            r_resp     <= bus.M_AXIL_RRESP;
            r_rdata    <= bus.M_AXIL_RDATA;
            r_rd_count <= r_rd_count + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.CMD_READY      = r_cmd_ready;
  assign bus.RSP_VALID      = w_rsp_valid;
  assign bus.RSP_WRITE      = r_write;
  assign bus.RSP_RDATA      = r_rdata;
  assign bus.RSP_RESP       = r_resp;
  assign bus.M_AXIL_AWADDR  = r_addr;
  assign bus.M_AXIL_AWVALID = w_awvalid;
  assign bus.M_AXIL_WDATA   = r_wdata;
  assign bus.M_AXIL_WSTRB   = r_wstrb;
  assign bus.M_AXIL_WVALID  = w_wvalid;
  assign bus.M_AXIL_BREADY  = w_bready;
  assign bus.M_AXIL_ARADDR  = r_addr;
  assign bus.M_AXIL_ARVALID = w_arvalid;
  assign bus.M_AXIL_RREADY  = w_rready;
  assign WR_COUNT           = r_wr_count;
  assign RD_COUNT           = r_rd_count;
  assign BUSY               = w_busy;
endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: the bench plays the AXI slave and the command
// source cycle by cycle and checks every output against hand-computed values.
module tb_axi_lite_master;
  logic        ACLK   = 1'b0;
  logic        ARESET = 1'b1;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic        busy;

  int n_vec  = 0;
  int n_err  = 0;
  int n_aw   = 0;
  int n_w    = 0;
  int aw0    = 0;
  int w0     = 0;

  axi_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .bus      (bus),
    .WR_COUNT (wr_count),
    .RD_COUNT (rd_count),
    .BUSY     (busy)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (bus.M_AXIL_AWVALID && bus.M_AXIL_AWREADY) n_aw <= n_aw + 1;
    if (bus.M_AXIL_WVALID && bus.M_AXIL_WREADY)   n_w  <= n_w + 1;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = w;
    bus.CMD_ADDR  = a;
    bus.CMD_WDATA = d;
    bus.CMD_WSTRB = s;
  endtask

  initial begin
    bus.CMD_VALID = 0; bus.CMD_WRITE = 0; bus.CMD_ADDR = '0; bus.CMD_WDATA = '0; bus.CMD_WSTRB = '0;
    bus.RSP_READY = 0;
    bus.M_AXIL_AWREADY = 0; bus.M_AXIL_WREADY = 0;
    bus.M_AXIL_BVALID = 0; bus.M_AXIL_BRESP = 2'b00;
    bus.M_AXIL_ARREADY = 0;
    bus.M_AXIL_RVALID = 0; bus.M_AXIL_RDATA = '0; bus.M_AXIL_RRESP = 2'b00;

    // Reset state
    #2;
    chk("rst_cmd_ready", 64'(bus.CMD_READY), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_awvalid",   64'(bus.M_AXIL_AWVALID), 64'd0);
    chk("rst_wr_count",  64'(wr_count), 64'd0);
    chk("rst_awaddr",    64'(bus.M_AXIL_AWADDR), 64'd0);
    tick(); tick();
    chk("rst_cmd_ready_held", 64'(bus.CMD_READY), 64'd0);
    ARESET = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 64'(bus.CMD_READY), 64'd1);

    // Zero-wait write 0x40 <- 0x0100ABCD
    bus.M_AXIL_AWREADY = 1; bus.M_AXIL_WREADY = 1;
    cmd(1'b1, 32'h40, 32'h0100ABCD, 4'hF);
    tick();
    bus.CMD_VALID = 0;
    chk("w1_awvalid", 64'(bus.M_AXIL_AWVALID), 64'd1);
    chk("w1_wvalid",  64'(bus.M_AXIL_WVALID), 64'd1);
    chk("w1_awaddr",  64'(bus.M_AXIL_AWADDR), 64'h40);
    chk("w1_wdata",   64'(bus.M_AXIL_WDATA), 64'h0100ABCD);
    chk("w1_wstrb",   64'(bus.M_AXIL_WSTRB), 64'hF);
    chk("w1_busy",    64'(busy), 64'd1);
    chk("w1_cmd_ready", 64'(bus.CMD_READY), 64'd0);
    tick();
    chk("w1_awvalid_drop", 64'(bus.M_AXIL_AWVALID), 64'd0);
    chk("w1_wvalid_drop",  64'(bus.M_AXIL_WVALID), 64'd0);
    chk("w1_bready",       64'(bus.M_AXIL_BREADY), 64'd1);
    chk("w1_rsp_early",    64'(bus.RSP_VALID), 64'd0);
    bus.M_AXIL_BVALID = 1; bus.M_AXIL_BRESP = 2'b00;
    tick();
    bus.M_AXIL_BVALID = 0;
    chk("w1_rsp_valid_n3", 64'(bus.RSP_VALID), 64'd1);
    chk("w1_rsp_write",    64'(bus.RSP_WRITE), 64'd1);
    chk("w1_rsp_resp",     64'(bus.RSP_RESP), 64'd0);
    chk("w1_rsp_rdata",    64'(bus.RSP_RDATA), 64'd0);
    chk("w1_wr_count",     64'(wr_count), 64'd1);
    chk("w1_bready_low",   64'(bus.M_AXIL_BREADY), 64'd0);
    bus.RSP_READY = 1;
    tick();
    bus.RSP_READY = 0;
    chk("w1_idle_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    chk("w1_idle_cmd_ready", 64'(bus.CMD_READY), 64'd1);
    chk("w1_idle_busy",      64'(busy), 64'd0);

    // Read 0x40 with RVALID five cycles late, then a stalled response
    bus.M_AXIL_ARREADY = 1;
    cmd(1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    bus.CMD_VALID = 0;
    chk("r1_arvalid", 64'(bus.M_AXIL_ARVALID), 64'd1);
    chk("r1_araddr",  64'(bus.M_AXIL_ARADDR), 64'h40);
    chk("r1_rready_pre", 64'(bus.M_AXIL_RREADY), 64'd0);
    tick();
    bus.M_AXIL_ARREADY = 0;
    chk("r1_arvalid_drop", 64'(bus.M_AXIL_ARVALID), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("r1_rready_wait", 64'(bus.M_AXIL_RREADY), 64'd1);
      chk("r1_rsp_wait",    64'(bus.RSP_VALID), 64'd0);
      tick();
    end
    bus.M_AXIL_RVALID = 1; bus.M_AXIL_RDATA = 32'h0100ABCD; bus.M_AXIL_RRESP = 2'b00;
    chk("r1_rready_hs", 64'(bus.M_AXIL_RREADY), 64'd1);
    tick();
    bus.M_AXIL_RVALID = 0; bus.M_AXIL_RDATA = 32'hFFFF_FFFF;
    chk("r1_rsp_valid", 64'(bus.RSP_VALID), 64'd1);
    chk("r1_rsp_rdata", 64'(bus.RSP_RDATA), 64'h0100ABCD);
    chk("r1_rsp_write", 64'(bus.RSP_WRITE), 64'd0);
    chk("r1_rd_count",  64'(rd_count), 64'd1);
    chk("r1_rready_low", 64'(bus.M_AXIL_RREADY), 64'd0);
    cmd(1'b1, 32'h99, 32'h5555_5555, 4'hF);
    for (int i = 0; i < 4; i++) begin
      chk("r1_stall_rsp_valid", 64'(bus.RSP_VALID), 64'd1);
      chk("r1_stall_rdata",     64'(bus.RSP_RDATA), 64'h0100ABCD);
      chk("r1_stall_cmd_ready", 64'(bus.CMD_READY), 64'd0);
      tick();
    end
    bus.CMD_VALID = 0;
    bus.RSP_READY = 1;
    tick();
    bus.RSP_READY = 0;
    chk("r1_done_cmd_ready", 64'(bus.CMD_READY), 64'd1);
    chk("r1_no_accept_aw",   64'(bus.M_AXIL_AWVALID), 64'd0);
    chk("r1_no_accept_busy", 64'(busy), 64'd0);
    chk("r1_wr_count_same",  64'(wr_count), 64'd1);

    // Write with WREADY three cycles after AWREADY, DECERR response
    aw0 = n_aw; w0 = n_w;
    bus.M_AXIL_AWREADY = 1; bus.M_AXIL_WREADY = 0;
    cmd(1'b1, 32'h44, 32'hDEADBEEF, 4'h3);
    tick();
    bus.CMD_VALID = 0;
    chk("w2_both_valid", 64'({bus.M_AXIL_AWVALID, bus.M_AXIL_WVALID}), 64'd3);
    tick();
    bus.M_AXIL_AWREADY = 0;
    chk("w2_aw_dropped", 64'({bus.M_AXIL_AWVALID, bus.M_AXIL_WVALID}), 64'd1);
    chk("w2_wdata",      64'(bus.M_AXIL_WDATA), 64'hDEADBEEF);
    chk("w2_wstrb",      64'(bus.M_AXIL_WSTRB), 64'h3);
    chk("w2_bready_early", 64'(bus.M_AXIL_BREADY), 64'd0);
    tick();
    chk("w2_w_held", 64'({bus.M_AXIL_AWVALID, bus.M_AXIL_WVALID}), 64'd1);
    tick();
    bus.M_AXIL_WREADY = 1;
    chk("w2_w_held2", 64'({bus.M_AXIL_AWVALID, bus.M_AXIL_WVALID}), 64'd1);
    tick();
    bus.M_AXIL_WREADY = 0;
    chk("w2_w_dropped", 64'(bus.M_AXIL_WVALID), 64'd0);
    chk("w2_bready",    64'(bus.M_AXIL_BREADY), 64'd1);
    bus.M_AXIL_BVALID = 1; bus.M_AXIL_BRESP = 2'b11;
    tick();
    bus.M_AXIL_BVALID = 0; bus.M_AXIL_BRESP = 2'b00;
    chk("w2_rsp_resp",  64'(bus.RSP_RESP), 64'h3);
    chk("w2_wr_count",  64'(wr_count), 64'd2);
    chk("w2_aw_hs_cnt", 64'(n_aw - aw0), 64'd1);
    chk("w2_w_hs_cnt",  64'(n_w - w0), 64'd1);
    bus.RSP_READY = 1;
    tick();
    bus.RSP_READY = 0;

    // Read with SLVERR and a two-cycle ARREADY stall
    cmd(1'b0, 32'h80, 32'h0, 4'h0);
    tick();
    bus.CMD_VALID = 0;
    chk("r2_arvalid", 64'(bus.M_AXIL_ARVALID), 64'd1);
    tick();
    chk("r2_arvalid_held", 64'(bus.M_AXIL_ARVALID), 64'd1);
    chk("r2_araddr",       64'(bus.M_AXIL_ARADDR), 64'h80);
    bus.M_AXIL_ARREADY = 1;
    tick();
    bus.M_AXIL_ARREADY = 0;
    bus.M_AXIL_RVALID = 1; bus.M_AXIL_RDATA = 32'h12345678; bus.M_AXIL_RRESP = 2'b10;
    tick();
    bus.M_AXIL_RVALID = 0; bus.M_AXIL_RRESP = 2'b00;
    chk("r2_rsp_resp",  64'(bus.RSP_RESP), 64'h2);
    chk("r2_rsp_rdata", 64'(bus.RSP_RDATA), 64'h12345678);
    chk("r2_rd_count",  64'(rd_count), 64'd2);
    bus.RSP_READY = 1;
    tick();
    bus.RSP_READY = 0;

    // Reset pulse while waiting in WR_B, then a clean write
    bus.M_AXIL_AWREADY = 1; bus.M_AXIL_WREADY = 1;
    cmd(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF);
    tick();
    bus.CMD_VALID = 0;
    tick();
    chk("rw_in_wr_b", 64'(bus.M_AXIL_BREADY), 64'd1);
    #2;
    ARESET = 1'b1;
    #1;
    chk("rw_async_bready",   64'(bus.M_AXIL_BREADY), 64'd0);
    chk("rw_async_busy",     64'(busy), 64'd0);
    chk("rw_async_cmd_rdy",  64'(bus.CMD_READY), 64'd0);
    chk("rw_async_counts",   64'({wr_count, rd_count}), 64'd0);
    chk("rw_async_addr",     64'(bus.M_AXIL_AWADDR), 64'd0);
    chk("rw_async_wdata",    64'(bus.M_AXIL_WDATA), 64'd0);
    chk("rw_async_rsp",      64'({bus.RSP_VALID, bus.RSP_WRITE, bus.RSP_RESP}), 64'd0);
    tick();
    ARESET = 1'b0;
    tick();
    chk("rw_cmd_ready", 64'(bus.CMD_READY), 64'd1);
    cmd(1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
    tick();
    bus.CMD_VALID = 0;
    chk("rw_awaddr", 64'(bus.M_AXIL_AWADDR), 64'h10);
    tick();
    bus.M_AXIL_BVALID = 1; bus.M_AXIL_BRESP = 2'b00;
    chk("rw_no_rsp_yet", 64'(bus.RSP_VALID), 64'd0);
    tick();
    bus.M_AXIL_BVALID = 0;
    chk("rw_rsp_valid", 64'(bus.RSP_VALID), 64'd1);
    chk("rw_wr_count",  64'(wr_count), 64'd1);
    chk("rw_rd_count",  64'(rd_count), 64'd0);
    bus.RSP_READY = 1;
    tick();
    bus.RSP_READY = 0;
    chk("rw_final_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
